instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter register. It takes the current PC and runs a request/acknowledge transaction against a variable-latency instruction memory. It holds the returned instruction in a fetch register with a valid/ready handshake toward decode, and pulses `pc_en` so the PC advances exactly once per fetched instruction. Branch/jump redirects arrive on `flush`, which discards in-flight or held instructions.

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, default widths and the NOP word.
package instr_fetch_unit_pkg;

    localparam int          IFU_DATA_WIDTH = 32;
    // MIPS sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] IFU_NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_FULL = 2'd2
    } fetch_state_e;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the valid/ready link to decode.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = IFU_DATA_WIDTH
);

    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;

    logic                  if_valid;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [DATA_WIDTH-1:0] if_pc;
    logic                  if_exc;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_instr, if_pc, if_exc,
        input  if_ready
    );

    // Memory and decode side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_instr, if_pc, if_exc,
        output if_ready
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding request to a variable-latency memory,
// a single fetch register toward decode, and a one-cycle pc_en pulse per fetched word.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(IFU_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_flush,
    output logic                  o_pc_en,
    instr_fetch_unit_if.master    bus
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;

    logic                  r_imem_req;
    logic [DATA_WIDTH-1:0] r_imem_addr;
    logic                  r_if_valid;
    logic [DATA_WIDTH-1:0] r_if_instr;
    logic [DATA_WIDTH-1:0] r_if_pc;
    logic                  r_if_exc;
    logic                  r_drop;

    logic                  w_aligned;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_req_set;
    logic                  w_exc_load;
    logic                  w_wait_ack;
    logic                  w_fetch_load;
    logic                  w_drop_set;
    logic                  w_valid_clr;

    assign w_aligned = is_aligned(i_pc[1:0]);
    assign w_accept  = r_if_valid && bus.if_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first, so every path drives the signal and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            FS_IDLE: begin
                if (!i_flush) begin
                    w_state_next = w_aligned ? FS_WAIT : FS_FULL;
                end
            end
            FS_WAIT: begin
                if (bus.imem_ack) begin
                    w_state_next = (r_drop || i_flush) ? FS_IDLE : FS_FULL;
                end
            end
            FS_FULL: begin
                if (i_flush) begin
                    w_state_next = FS_IDLE;
                end else if (w_accept) begin
                    w_state_next = w_aligned ? FS_WAIT : FS_FULL;
                end
            end
            default: w_state_next = FS_IDLE;
        endcase
    end

    // Output/control decode. A flush always overrides an accept on the same edge.
    always_comb begin
        w_issue      = (r_state == FS_IDLE) || ((r_state == FS_FULL) && w_accept);
        w_req_set    = w_issue && !i_flush && w_aligned;
        w_exc_load   = w_issue && !i_flush && !w_aligned;
        w_wait_ack   = (r_state == FS_WAIT) && bus.imem_ack;
        w_fetch_load = w_wait_ack && !r_drop && !i_flush;
        w_drop_set   = (r_state == FS_WAIT) && !bus.imem_ack && i_flush;
        w_valid_clr  = (r_state == FS_FULL) && (i_flush || w_accept);
    end

    assign o_pc_en = w_fetch_load;

    // Request channel and drop flag. A request is held until acked, even across a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_drop      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (w_req_set) begin
                r_imem_req  <= 1'b1;
                r_imem_addr <= i_pc;
            end else if (w_wait_ack) begin
                r_imem_req  <= 1'b0;
            end

            if (w_wait_ack) begin
                r_drop <= 1'b0;
            end else if (w_drop_set) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Fetch register bank toward decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= '0;
            r_if_exc   <= 1'b0;
        end else if (w_fetch_load) begin
            r_if_valid <= 1'b1;
            r_if_instr <= bus.imem_rdata;
            r_if_pc    <= r_imem_addr;
            r_if_exc   <= 1'b0;
        end else if (w_exc_load) begin
            r_if_valid <= 1'b1;
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= i_pc;
            r_if_exc   <= 1'b1;
        end else if (w_valid_clr) begin
            r_if_valid <= 1'b0;
            if (i_flush) begin
                r_if_instr <= NOP_INSTR;
            end
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_exc    = r_if_exc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed corner cases, then random traffic
// against a program-order model of which instruction decode should receive next.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        pc_en;
    logic [31:0] pc = 32'h0;
    logic [31:0] flush_tgt = 32'h0;

    int     n_cmp   = 0;
    int     n_bad   = 0;
    int     n_deliv = 0;
    int     pc_cnt  = 0;
    int     lat_cfg = 0;
    logic   force_ack = 1'b0;
    fetch_t exp_q[$];

    instr_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    instr_fetch_unit #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_pc    (pc),
        .i_flush (flush),
        .o_pc_en (pc_en),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image: a known word at 0, otherwise an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // What decode must see for a fetch at address a.
    function automatic fetch_t ref_fetch(input logic [31:0] a);
        fetch_t f;
        f.pc    = a;
        f.exc   = (a[1:0] != 2'b00);
        f.instr = f.exc ? IFU_NOP_INSTR : mem_word(a);
        return f;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !bus.if_valid; i++) cyc();
        check("wait_if_valid", bus.if_valid, 1);
    endtask

    task automatic do_flush(input logic [31:0] tgt);
        flush     = 1'b1;
        flush_tgt = tgt;
        exp_q.delete();
        exp_q.push_back(ref_fetch(tgt));
    endtask

    // Instruction memory: acks after lat cycles of a held request (lat_cfg<0 picks 0..4).
    initial begin : responder
        int   cnt;
        int   lat_cur;
        logic just_acked;
        cnt = 0; lat_cur = 0; just_acked = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 32'h0;
                cnt = 0; just_acked = 1'b0;
            end else if (bus.imem_req && !just_acked) begin
                if (cnt == 0) lat_cur = (lat_cfg < 0) ? int'($urandom_range(0, 4)) : lat_cfg;
                if (cnt >= lat_cur) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    cnt = 0; just_acked = 1'b1;
                end else begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = 32'hDEAD_BEEF;
                    cnt++;
                end
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 32'hDEAD_BEEF;
                cnt = 0; just_acked = 1'b0;
            end
        end
    end

    // Upstream PC register: flush target wins, else +4 on pc_en.
    initial begin : pc_reg
        logic        en_s, fl_s, rst_s;
        logic [31:0] tgt_s;
        forever begin
            @(negedge clk);
            en_s = pc_en; fl_s = flush; tgt_s = flush_tgt; rst_s = rst;
            @(posedge clk);
            #1;
            if (rst_s && en_s) pc_cnt++;
            if (!rst_s)    pc = 32'h0;
            else if (fl_s) pc = tgt_s;
            else if (en_s) pc = pc + 32'd4;
        end
    end

    // Monitor: protocol checks plus scoreboard pop on every decode handshake.
    initial begin : monitor
        logic        p_req, p_ack, p_valid, p_ready, p_flush, p_exc;
        logic [31:0] p_addr, p_instr, p_pc;
        fetch_t      e;
        p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0; p_flush = 0; p_exc = 0;
        p_addr = 0; p_instr = 0; p_pc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (pc_en)
                    check("pc_en_qualified", {29'd0, bus.imem_req, bus.imem_ack, flush}, 32'd6);
                if (p_req && !p_ack) begin
                    check("imem_req_held", bus.imem_req, 1);
                    check("imem_addr_stable", bus.imem_addr, p_addr);
                end
                if (p_valid && !p_ready && !p_flush) begin
                    check("stall_if_valid", bus.if_valid, 1);
                    check("stall_if_instr", bus.if_instr, p_instr);
                    check("stall_if_pc", bus.if_pc, p_pc);
                    check("stall_if_exc", bus.if_exc, p_exc);
                end
                if (bus.if_valid && bus.if_ready && !flush) begin
                    check("sb_entry_present", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("deliv_if_pc", bus.if_pc, e.pc);
                        check("deliv_if_instr", bus.if_instr, e.instr);
                        check("deliv_if_exc", bus.if_exc, e.exc);
                        n_deliv++;
                        exp_q.push_back(ref_fetch(e.exc ? e.pc : e.pc + 32'd4));
                    end
                end
            end
            p_req   = rst && bus.imem_req;
            p_ack   = bus.imem_ack;
            p_addr  = bus.imem_addr;
            p_valid = rst && bus.if_valid;
            p_ready = bus.if_ready;
            p_flush = flush;
            p_instr = bus.if_instr;
            p_pc    = bus.if_pc;
            p_exc   = bus.if_exc;
        end
    end

    initial begin : stimulus
        int          n0;
        int          d0;
        logic [31:0] t;
        bus.if_ready = 1'b1;
        lat_cfg      = 0;

        // Reset held three cycles with ack forced high.
        rst = 1'b0; force_ack = 1'b1;
        repeat (3) begin
            cyc();
            check("rst_imem_req", bus.imem_req, 0);
            check("rst_if_valid", bus.if_valid, 0);
            check("rst_if_instr", bus.if_instr, IFU_NOP_INSTR);
            check("rst_pc_en", pc_en, 0);
        end
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_if_pc", bus.if_pc, 0);
        check("rst_if_exc", bus.if_exc, 0);
        force_ack = 1'b0;
        exp_q.push_back(ref_fetch(32'h0));
        rst = 1'b1;

        // Zero-wait fetch from 0.
        cyc();
        check("zw_req", bus.imem_req, 1);
        check("zw_addr", bus.imem_addr, 32'h0);
        cyc();
        check("zw_if_valid", bus.if_valid, 1);
        check("zw_if_instr", bus.if_instr, 32'h2008_0005);
        check("zw_if_pc", bus.if_pc, 32'h0);
        check("zw_pc_en_pulses", pc_cnt, 1);
        cyc();
        check("zw_next_req", bus.imem_req, 1);
        check("zw_next_addr", bus.imem_addr, 32'h4);
        check("zw_valid_cleared", bus.if_valid, 0);
        repeat (12) cyc();

        // Wait states plus a four-cycle decode stall.
        lat_cfg = 3;
        bus.if_ready = 1'b0;
        wait_valid(20);
        repeat (4) begin
            cyc();
            check("stall_no_new_req", bus.imem_req, 0);
            check("stall_valid_held", bus.if_valid, 1);
        end

        // Flush in cycle 1 of a 3-cycle wait, redirect to 0x40.
        bus.if_ready = 1'b1;
        cyc();
        check("fw_req_issued", bus.imem_req, 1);
        cyc();
        n0 = pc_cnt;
        do_flush(32'h40);
        cyc();
        flush = 1'b0;
        check("fw_valid_c2", bus.if_valid, 0);
        cyc();
        check("fw_pc_en_on_ack", pc_en, 0);
        check("fw_valid_c3", bus.if_valid, 0);
        cyc();
        check("fw_valid_after", bus.if_valid, 0);
        cyc();
        check("fw_new_req", bus.imem_req, 1);
        check("fw_new_addr", bus.imem_addr, 32'h40);
        check("fw_no_pc_en", pc_cnt, n0);

        // Flush coincident with ack, redirect to 0x80.
        repeat (3) cyc();
        do_flush(32'h80);
        #1;
        check("fa_pc_en", pc_en, 0);
        cyc();
        flush = 1'b0;
        check("fa_if_valid", bus.if_valid, 0);
        check("fa_req_dropped", bus.imem_req, 0);
        cyc();
        check("fa_new_addr", bus.imem_addr, 32'h80);

        // Flush in FULL with if_ready high.
        bus.if_ready = 1'b0;
        wait_valid(20);
        bus.if_ready = 1'b1;
        do_flush(32'h100);
        cyc();
        flush = 1'b0;
        check("ff_if_valid", bus.if_valid, 0);
        check("ff_if_instr", bus.if_instr, IFU_NOP_INSTR);
        lat_cfg = 0;
        repeat (10) cyc();

        // Misaligned PC 0x6.
        bus.if_ready = 1'b0;
        wait_valid(20);
        do_flush(32'h6);
        cyc();
        flush = 1'b0;
        check("mis_no_req_idle", bus.imem_req, 0);
        cyc();
        check("mis_no_req", bus.imem_req, 0);
        check("mis_if_valid", bus.if_valid, 1);
        check("mis_if_exc", bus.if_exc, 1);
        check("mis_if_pc", bus.if_pc, 32'h6);
        check("mis_if_instr", bus.if_instr, IFU_NOP_INSTR);
        check("mis_pc_en", pc_en, 0);
        bus.if_ready = 1'b1;
        repeat (3) cyc();
        do_flush(32'h200);
        cyc();
        flush = 1'b0;

        // Random traffic: random ack latency, decode stalls and redirects.
        lat_cfg = -1;
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            bus.if_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                t = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
                do_flush(t);
            end else begin
                flush = 1'b0;
            end
            cyc();
        end
        flush = 1'b0;
        check("random_progress", (n_deliv - d0) > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
